// File: rtl/bcd_scan_display_pkg.sv
// Shared definitions for the BCD scan display.
// Contents: FSM state type, segment constants, and the double-dabble nibble
// adjust helper used by the conversion datapath.
package bcd_scan_display_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam int unsigned BCD_W = 40;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int unsigned i = 0; i < BCD_W / 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_scan_display_seg7_dec.sv
// seg7_dec: combinational BCD digit to active-low 7-segment decoder.
// Ports:
//   digit  in  4  BCD digit 0..9
//   seg    out 7  segments {g,f,e,d,c,b,a}, active-low; non-BCD input blanks
module seg7_dec
  import bcd_scan_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: loads a binary value, converts it to BCD with a
// sequential double-dabble FSM, and time-multiplexes the low four decimal
// digits onto one active-low 7-segment bus.
// Ports:
//   clock     in   1      rising-edge clock
//   reset     in   1      asynchronous active-low reset
//   value     in   WIDTH  unsigned value, sampled on an accepted load
//   load      in   1      start strobe, honoured only in IDLE
//   busy      out  1      high while converting (SHIFT or DONE)
//   overflow  out  1      last converted value exceeded 9999
//   data      out  7      active-low segments {g,f,e,d,c,b,a}
//   control   out  4      active-low one-hot anodes, bit n = digit n
module bcd_scan_display
  import bcd_scan_display_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SCAN_DIV = 125000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic             overflow,
  output logic [6:0]       data,
  output logic [3:0]       control
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t                   state;
  logic [WIDTH-1:0]         bin;
  logic [BCD_W-1:0]         bcd;
  logic [BCD_W-1:0]         bcd_adj;
  logic [BCD_W+WIDTH-1:0]   shifted;
  logic [5:0]               cnt;
  logic [15:0]              disp;
  logic [PW-1:0]            presc;
  logic [1:0]               idx;
  logic [3:0]               sel_digit;
  logic [6:0]               sel_seg;
  logic                     sel_blank;
  logic [6:0]               next_data;

  assign bcd_adj = dabble_adjust(bcd);
  assign shifted = {bcd_adj, bin} << 1;

  // Conversion FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      overflow <= 1'b0;
      disp     <= '0;
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            bin   <= value;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd <= shifted[BCD_W+WIDTH-1:WIDTH];
          bin <= shifted[WIDTH-1:0];
          cnt <= cnt + 6'd1;
          if (cnt == 6'(WIDTH - 1)) state <= S_DONE;
        end
        S_DONE: begin
          disp     <= bcd[15:0];
          overflow <= |bcd[BCD_W-1:16];
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Free-running digit scan
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign sel_digit = disp[{idx, 2'b00} +: 4];

  seg7_dec u_dec (
    .digit (sel_digit),
    .seg   (sel_seg)
  );

  // A digit is a leading zero when it and every more significant digit are zero;
  // digit 0 always shows so a zero value reads "0".
  always_comb begin
    sel_blank = 1'b0;
    case (idx)
      2'd1:    sel_blank = (disp[15:4]  == '0);
      2'd2:    sel_blank = (disp[15:8]  == '0);
      2'd3:    sel_blank = (disp[15:12] == '0);
      default: sel_blank = 1'b0;
    endcase
  end

  always_comb begin
    next_data = sel_seg;
    if (overflow)                  next_data = SEG_DASH;
    else if (BLANK_LZ && sel_blank) next_data = SEG_BLANK;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data    <= SEG_BLANK;
      control <= '1;
    end else begin
      data    <= next_data;
      control <= ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display (WIDTH=32, SCAN_DIV=4); a second
// instance with leading-zero blanking disabled shares all inputs.
module tb_bcd_scan_display;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned SCAN_DIV = 4;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00, S9 = 7'h10;
  localparam logic [6:0] SB = 7'h7F, SD = 7'h3F;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] value = '0;
  logic             load  = 1'b0;
  logic             busy, overflow, busy0, overflow0;
  logic [6:0]       data, data0;
  logic [3:0]       control, control0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  bcd_scan_display #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut (
    .clock(clock), .reset(reset), .value(value), .load(load),
    .busy(busy), .overflow(overflow), .data(data), .control(control)
  );

  bcd_scan_display #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut0 (
    .clock(clock), .reset(reset), .value(value), .load(load),
    .busy(busy0), .overflow(overflow0), .data(data0), .control(control0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] pk(input logic [6:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  // Watch 16 cycles (one full rotation) and check each visible digit on both instances.
  task automatic check_scan(input string tag, input logic [27:0] e1, input logic [27:0] e0);
    int k;
    logic [27:0] t;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      case (control)
        4'hE: k = 0;
        4'hD: k = 1;
        4'hB: k = 2;
        4'h7: k = 3;
        default: k = -1;
      endcase
      chk({tag, "_onehot"}, 32'(k >= 0), 32'd1);
      if (k >= 0) begin
        t = e1 >> (7 * k);
        chk({tag, "_data"}, 32'(data), 32'(t[6:0]));
        t = e0 >> (7 * k);
        chk({tag, "_data_nolz"}, 32'(data0), 32'(t[6:0]));
      end
    end
  endtask

  task automatic run_conv(input string tag, input logic [WIDTH-1:0] v, input bit dup,
                          input logic exp_ovf);
    int n;
    @(negedge clock);
    value = v;
    load  = 1'b1;
    @(negedge clock);
    load = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (dup && n == 5) begin
        value = 77;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clock);
    end
    load = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(n), 32'd33);
    chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_overflow_nolz"}, 32'(overflow0), 32'(exp_ovf));
  endtask

  initial begin
    logic [3:0] ec;

    // 1. reset, then scan of a zero display
    repeat (3) @(negedge clock);
    chk("rst_data", 32'(data), 32'(SB));
    chk("rst_control", 32'(control), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clock);
      ec = ~(4'b0001 << ((n - 1) / 4));
      chk("scan_control", 32'(control), 32'(ec));
      chk("scan_data", 32'(data), (n <= 4) ? 32'(S0) : 32'(SB));
      chk("scan_data_nolz", 32'(data0), 32'(S0));
    end

    // 2. 1234
    run_conv("v1234", 1234, 1'b0, 1'b0);
    check_scan("v1234", pk(S1, S2, S3, S4), pk(S1, S2, S3, S4));

    // 3. 7 with and without leading-zero blanking
    run_conv("v7", 7, 1'b0, 1'b0);
    check_scan("v7", pk(SB, SB, SB, S7), pk(S0, S0, S0, S7));

    // 4. overflow boundary
    run_conv("v10000", 10000, 1'b0, 1'b1);
    check_scan("v10000", pk(SD, SD, SD, SD), pk(SD, SD, SD, SD));
    run_conv("v9999", 9999, 1'b0, 1'b0);
    check_scan("v9999", pk(S9, S9, S9, S9), pk(S9, S9, S9, S9));

    // 5. load while busy is ignored
    run_conv("v42", 42, 1'b1, 1'b0);
    check_scan("v42", pk(SB, SB, S4, S2), pk(S0, S0, S4, S2));

    // 6. reset mid-conversion
    @(negedge clock);
    value = 5678;
    load  = 1'b1;
    @(negedge clock);
    load = 1'b0;
    repeat (9) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_data", 32'(data), 32'(SB));
    chk("abort_control", 32'(control), 32'hF);
    @(negedge clock);
    reset = 1'b1;
    check_scan("abort_zero", pk(SB, SB, SB, S0), pk(S0, S0, S0, S0));
    chk("abort_no_done", 32'(busy), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    run_conv("v5678", 5678, 1'b0, 1'b0);
    check_scan("v5678", pk(S5, S6, S7, S8), pk(S5, S6, S7, S8));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
